// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg -- shared definitions for the 8N1 UART receive path.
//   rx_state_t : receiver FSM state encoding
//   START_BIT  : line level of a start bit
//   STOP_BIT   : line level of a stop bit
//   DATA_BITS  : data bits per 8N1 frame
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if -- valid/ready holding-register handoff from the receiver to its consumer.
//   data_out   : received byte, stable while data_valid=1
//   data_valid : holding register full
//   data_ready : consumer accepts data_out on a clk edge where data_valid=1
// master = receiver side, slave = consumer side.
interface uart_rx_if;

  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;

  modport master (output data_out, output data_valid, input data_ready);
  modport slave  (input data_out, input data_valid, output data_ready);

endinterface

// File: rtl/uart_rx_baud_tick_gen.sv
// baud_tick_gen -- divides clk down to the oversampling tick rate.
//   clk     : system clock
//   rst     : synchronous, active-high reset
//   restart : force the divider back to count 0 (aligns ticks to a start edge)
//   tick    : one-cycle pulse every DIVISOR clk cycles
module baud_tick_gen #(
  parameter int DIVISOR = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

  logic [CW-1:0] count;
  logic          wrap;

  assign wrap = (count == CW'(DIVISOR - 1));
  // A restart cycle never produces a tick, so the first tick after a start
  // edge lands a full DIVISOR cycles later.
  assign tick = wrap && !restart;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      count <= '0;
    end else if (wrap) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver with oversampled mid-bit sampling.
//   clk       : system clock
//   rst       : synchronous, active-high reset
//   enable    : permits detection of new start bits
//   rx_line   : asynchronous serial input, idle high
//   bus       : valid/ready holding register toward the consumer (master side)
//   rx_busy   : high whenever the FSM is not in IDLE
//   frame_err : one-cycle pulse, stop bit sampled low
//   overrun   : one-cycle pulse, completed byte dropped because the holding register was full
// OVERSAMPLE must be even and >= 8.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DIVISOR    = 27,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      enable,
  input  logic      rx_line,
  uart_rx_if.master bus,
  output logic      rx_busy,
  output logic      frame_err,
  output logic      overrun
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  logic                 rx_meta;
  logic                 rx_s;
  rx_state_t            state;
  logic [SW-1:0]        sample_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 tick;
  logic                 restart;
  logic                 mid_bit;
  logic                 end_bit;

  // NOTE: the synchronizer resets to the idle line level (1); resetting it
  // to 0 would look like a start bit the moment reset is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_line;
      rx_s    <= rx_meta;
    end
  end

  assign restart = (state == ST_IDLE) && enable && (rx_s == START_BIT);
  assign mid_bit = (sample_cnt == SW'(OVERSAMPLE / 2 - 1));
  assign end_bit = (sample_cnt == SW'(OVERSAMPLE - 1));

  baud_tick_gen #(.DIVISOR(DIVISOR)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      sample_cnt     <= '0;
      bit_cnt        <= '0;
      shift          <= '0;
      bus.data_out   <= '0;
      bus.data_valid <= 1'b0;
      rx_busy        <= 1'b0;
      frame_err      <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      // NOTE: this consumer-accept clear is a default; a delivery further
      // down in the same cycle overrides it because the last non-blocking
      // assignment to data_valid wins.
      if (bus.data_valid && bus.data_ready) begin
        bus.data_valid <= 1'b0;
      end

      unique case (state)
        ST_IDLE: begin
          if (restart) begin
            state      <= ST_START;
            sample_cnt <= '0;
            rx_busy    <= 1'b1;
          end
        end

        ST_START: begin
          if (tick) begin
            if (mid_bit && rx_s != START_BIT) begin
              // Glitch shorter than half a bit: quietly drop it.
              state      <= ST_IDLE;
              sample_cnt <= '0;
              rx_busy    <= 1'b0;
            end else if (end_bit) begin
              state      <= ST_DATA;
              sample_cnt <= '0;
              bit_cnt    <= '0;
            end else begin
              sample_cnt <= sample_cnt + SW'(1);
            end
          end
        end

        ST_DATA: begin
          if (tick) begin
            if (mid_bit) begin
              shift <= {rx_s, shift[DATA_BITS-1:1]};  // LSB arrives first
            end
            if (end_bit) begin
              sample_cnt <= '0;
              if (bit_cnt == BW'(DATA_BITS - 1)) begin
                state <= ST_STOP;
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end else begin
              sample_cnt <= sample_cnt + SW'(1);
            end
          end
        end

        ST_STOP: begin
          if (tick) begin
            if (mid_bit) begin
              sample_cnt <= '0;
              if (rx_s == STOP_BIT) begin
                // Leave at mid-stop so a back-to-back start edge is not missed.
                state   <= ST_IDLE;
                rx_busy <= 1'b0;
                if (!bus.data_valid || bus.data_ready) begin
                  bus.data_out   <= shift;
                  bus.data_valid <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
              end else begin
                frame_err <= 1'b1;
                state     <= ST_WAIT_HIGH;
              end
            end else begin
              sample_cnt <= sample_cnt + SW'(1);
            end
          end
        end

        ST_WAIT_HIGH: begin
          // A held-low break must return high before a new start is allowed.
          if (rx_s == STOP_BIT) begin
            state   <= ST_IDLE;
            rx_busy <= 1'b0;
          end
        end

        default: begin
          state   <= ST_IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- self-checking bench for uart_rx (DIVISOR=4, OVERSAMPLE=16: 64 clk per bit).
module tb_uart_rx;

  localparam int BIT_CLK = 64;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic rx_line;
  logic rx_busy;
  logic frame_err;
  logic overrun;

  uart_rx_if bus_if ();

  uart_rx #(.DIVISOR(4), .OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .rx_line   (rx_line),
    .bus       (bus_if),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  int         ferr_cnt = 0;
  int         ovr_cnt  = 0;
  int         both_cnt = 0;
  int         rise_cnt = 0;
  logic [7:0] byte_log[$];
  logic       prev_v   = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (frame_err && overrun) both_cnt++;
      if (bus_if.data_valid && !prev_v) begin
        rise_cnt++;
        byte_log.push_back(bus_if.data_out);
      end
      prev_v = bus_if.data_valid;
    end
  end

  // All drive tasks start and end at posedge+1.
  task automatic send_bit(input logic v);
    rx_line = v;
    repeat (BIT_CLK) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_val);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_val);
    if (!stop_val) begin
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
    end
  endtask

  task automatic idle_clk(input int n);
    rx_line = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ack_byte();
    bus_if.data_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_if.data_ready = 1'b0;
  endtask

  typedef struct {
    logic [7:0] tx;
    logic       stop_val;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int f0, o0, r0;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 0};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1};
    vecs[2] = '{8'h81, 1'b1, 1'b1, 8'h81, 0};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};
    vecs[5] = '{8'h01, 1'b1, 1'b1, 8'h01, 0};
    vecs[6] = '{8'h80, 1'b0, 1'b0, 8'h00, 1};
    vecs[7] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 0};

    rst               = 1'b1;
    enable            = 1'b1;
    rx_line           = 1'b1;
    bus_if.data_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("reset_data_out", bus_if.data_out, 8'h00);
    check("reset_valid", bus_if.data_valid, 1'b0);
    check("reset_busy", rx_busy, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_overrun", overrun, 1'b0);
    idle_clk(10);

    // Latency of the first delivery, measured from the start falling edge.
    n = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (!bus_if.data_valid && n < 2000) begin
          @(posedge clk);
          #1;
          n++;
        end
      end
    join
    check("latency_608_612", (n >= 608 && n <= 612) ? 1 : 0, 1);
    check("latency_data", bus_if.data_out, 8'hA5);
    ack_byte();
    check("latency_ack_clears", bus_if.data_valid, 1'b0);
    idle_clk(20);

    // Table-driven single frames.
    for (int i = 0; i < 8; i++) begin
      f0 = ferr_cnt;
      o0 = ovr_cnt;
      send_frame(vecs[i].tx, vecs[i].stop_val);
      idle_clk(BIT_CLK);
      check($sformatf("vec%0d_valid", i), bus_if.data_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) check($sformatf("vec%0d_data", i), bus_if.data_out, vecs[i].exp_data);
      check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
      check($sformatf("vec%0d_ovr", i), ovr_cnt - o0, 0);
      ack_byte();
      check($sformatf("vec%0d_ack", i), bus_if.data_valid, 1'b0);
    end

    // False start: 16 clk low pulse.
    f0 = ferr_cnt;
    r0 = rise_cnt;
    rx_line = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    rx_line = 1'b1;
    check("false_start_busy_high", rx_busy, 1'b1);
    repeat (24) @(posedge clk);
    #1;
    check("false_start_busy_low", rx_busy, 1'b0);
    idle_clk(BIT_CLK * 2);
    check("false_start_no_valid", rise_cnt - r0, 0);
    check("false_start_no_ferr", ferr_cnt - f0, 0);

    // Overrun: back-to-back frames with the consumer stalled.
    o0 = ovr_cnt;
    f0 = ferr_cnt;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle_clk(BIT_CLK);
    check("overrun_held", bus_if.data_out, 8'h11);
    check("overrun_valid", bus_if.data_valid, 1'b1);
    check("overrun_pulses", ovr_cnt - o0, 1);
    check("overrun_no_ferr", ferr_cnt - f0, 0);
    ack_byte();
    check("overrun_ack", bus_if.data_valid, 1'b0);

    // Back-to-back with the consumer always ready.
    byte_log.delete();
    r0 = rise_cnt;
    o0 = ovr_cnt;
    f0 = ferr_cnt;
    bus_if.data_ready = 1'b1;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle_clk(BIT_CLK);
    bus_if.data_ready = 1'b0;
    check("b2b_count", rise_cnt - r0, 2);
    if (byte_log.size() == 2) begin
      check("b2b_first", byte_log[0], 8'h00);
      check("b2b_second", byte_log[1], 8'hFF);
    end else begin
      check("b2b_log_size", byte_log.size(), 2);
    end
    check("b2b_flags", (ovr_cnt - o0) + (ferr_cnt - f0), 0);

    // Reset mid-frame with a byte already held.
    send_frame(8'h77, 1'b1);
    idle_clk(BIT_CLK);
    check("pre_reset_held", bus_if.data_valid, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midreset_valid", bus_if.data_valid, 1'b0);
    check("midreset_data", bus_if.data_out, 8'h00);
    check("midreset_busy", rx_busy, 1'b0);
    check("midreset_flags", {frame_err, overrun}, 2'b00);
    r0 = rise_cnt;
    idle_clk(BIT_CLK * 8);
    check("midreset_no_partial", rise_cnt - r0, 0);
    send_frame(8'h5A, 1'b1);
    idle_clk(BIT_CLK);
    check("post_reset_valid", bus_if.data_valid, 1'b1);
    check("post_reset_data", bus_if.data_out, 8'h5A);
    ack_byte();

    // enable=0 blocks new frames.
    enable = 1'b0;
    r0 = rise_cnt;
    send_frame(8'hC3, 1'b1);
    idle_clk(BIT_CLK);
    check("disabled_no_valid", rise_cnt - r0, 0);
    check("disabled_busy", rx_busy, 1'b0);
    enable = 1'b1;

    check("flags_exclusive", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver for the io block; the receive-side counterpart of the transceiver's transmitter.
- Samples rx_line with oversampling, assembles LSB-first bytes and hands each byte to the consumer (control/loader) over a valid/ready holding register.
- Flags framing errors and overruns.

Parameters:
DIVISOR, 27, clk cycles per oversample tick (50 MHz / (115200*16) rounded)
OVERSAMPLE, 16, ticks per bit; must be even, >= 8
DATA_BITS, 8, data bits per frame (fixed 8 for this design; parameter kept for the bench)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  permits detection of new start bits
rx_line  in  1  asynchronous serial input, idle high
data_out  out  8  received byte, stable while data_valid=1
data_valid  out  1  holding register full
data_ready  in  1  consumer accepts data_out on a clk edge where data_valid=1
rx_busy  out  1  high in any state other than IDLE
frame_err  out  1  one-cycle pulse: stop bit sampled 0
overrun  out  1  one-cycle pulse: completed byte dropped because holding register full

Behaviour:
- Reset (sync, rst=1 at posedge clk):
  - state=IDLE; synchronizer flops=1; tick/sample/bit counters=0; shift reg=0.
  - data_out=0, data_valid=0, rx_busy=0, frame_err=0, overrun=0.
  - Reset mid-frame discards the partial byte and any held byte.
- Input path: 2-flop synchronizer, rx_s, reset to 1. All decisions use rx_s; added latency is 2 clk.
- Tick generator:
  - Counts 0..DIVISOR-1 and emits a 1-cycle tick on wrap.
  - Restarted (count=0) on start-bit detection so sampling aligns to the falling edge.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: enable=1 and rx_s=0 -> START, sample count=0. enable=0 -> stay, line ignored.
  - START: at sample count OVERSAMPLE/2-1 (mid start bit):
    - rx_s=1 -> false start -> IDLE, no flags.
    - rx_s=0 -> continue; at count OVERSAMPLE-1 -> DATA, bit=0.
  - DATA:
    - Sample rx_s at the mid-bit tick and shift it in LSB-first.
    - After DATA_BITS bits (end of last bit period) -> STOP.
  - STOP, at the mid-bit tick:
    - rx_s=1 -> deliver byte, -> IDLE. Leaving at mid-stop allows back-to-back frames.
    - rx_s=0 -> frame_err pulse, byte discarded, -> WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s=1, then -> IDLE (a break condition never retriggers).
- enable deasserted mid-frame: current frame completes normally; only new starts are blocked.
- Delivery (cycle after mid-stop sample):
  - data_valid=0: data_out<=byte, data_valid<=1.
  - data_valid=1 and data_ready=1 that cycle: new byte loaded, data_valid stays 1, no overrun.
  - data_valid=1 and data_ready=0: overrun pulse, new byte dropped, held byte unchanged.
- Consumer handshake: data_valid=1 and data_ready=1 at a posedge with no delivery -> data_valid<=0 next cycle. data_ready while data_valid=0 is ignored.
- frame_err and overrun are never both asserted in the same cycle.

Decomposition:
- Shared include (uart_defs.vh): state encodings and 8N1 frame constants (start=0, stop=1, DATA_BITS). The transmitter uses the same file.
- Sub-module baud_tick_gen (DIVISOR, with restart input), also reusable by the transmitter.

Test Plan:
(All with DIVISOR=4, OVERSAMPLE=16, so 1 bit = 64 clk.)
1. Send 0xA5, data_ready=0:
   - data_out=0xA5 and data_valid rises within 9.5 bits + 4 clk (608..612 clk) of the start falling edge.
   - Then data_ready=1 for 1 clk -> data_valid=0 next cycle.
2. rx_line low for 16 clk, then high:
   - No data_valid, no frame_err.
   - rx_busy drops within 32+4 clk; state IDLE.
3. Send 0x3C with stop bit 0, line held low 2 more bits, then high, then send 0x81:
   - Exactly one frame_err pulse, no data_valid for 0x3C.
   - data_out=0x81 received correctly.
4. Send 0x11 then 0x22 back-to-back, data_ready=0:
   - data_out=0x11 retained; one overrun pulse at the second delivery.
   - After ready, data_valid=0.
5. Send 0x00 and 0xFF back-to-back (no idle gap), data_ready=1: two data_valid events with data_out 0x00 then 0xFF, no flags.
6. rst=1 for 1 clk after 3 data bits of a frame:
   - All outputs at reset values next cycle; the partial byte is never delivered.
   - A subsequent 0x5A is received correctly.
   - With enable=0, a sent byte yields no data_valid.
